// File: rtl/column_step_scheduler.sv
// Sequences one time step across NUM_COL column units per audio request.
// It also manages the rho hand-off and the sample output stream.
module column_step_scheduler #(
    parameter int          NUM_COL = 8,
    parameter int          TIMEOUT = 1023,
    parameter logic [17:0] RHO_RST = 18'h01000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                audio_req,
    input  logic [17:0]         rho_in,
    input  logic                rho_wr,
    output logic [17:0]         rho_out,
    output logic                init_req,
    input  logic                init_done,
    output logic                col_start,
    input  logic [NUM_COL-1:0]  col_done_vec,
    input  logic signed [17:0]  center_amp,
    output logic signed [17:0]  sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [31:0]         step_count,
    output logic [7:0]          overrun_cnt,
    output logic                timeout_err,
    output logic                busy
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_REQ,
        S_START,
        S_COLLECT,
        S_EMIT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [17:0]               r_rho_shadow;
    logic [17:0]               r_rho_out;
    logic signed [17:0]        r_sample;
    logic [31:0]               r_step_count;
    logic [7:0]                r_overrun;
    logic                      r_timeout_err;
    logic                      r_pending;
    logic [NUM_COL-1:0]        r_mask;
    logic [TW-1:0]             r_timer;

    logic [NUM_COL-1:0]        w_mask_nxt;
    logic                      w_mask_full;
    logic                      w_timeout;
    logic                      w_take_req;

    // Done pulses are folded in combinationally so EMIT follows the last bit by one cycle.
    assign w_mask_nxt  = r_mask | col_done_vec;
    assign w_mask_full = &w_mask_nxt;
    assign w_timeout   = (r_timer == TMR_LAST) && !w_mask_full;
    assign w_take_req  = (r_state == S_WAIT_REQ) && run && (audio_req || r_pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        init_req     = 1'b0;
        col_start    = 1'b0;
        sample_valid = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) w_state_nxt = S_INIT;
            end
            S_INIT: begin
                init_req = 1'b1;
                if (init_done) w_state_nxt = S_WAIT_REQ;
            end
            S_WAIT_REQ: begin
                busy = 1'b0;
                if (!run)            w_state_nxt = S_IDLE;
                else if (w_take_req) w_state_nxt = S_START;
            end
            S_START: begin
                col_start   = 1'b1;
                w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_mask_full)    w_state_nxt = S_EMIT;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_EMIT: begin
                sample_valid = 1'b1;
                if (sample_ready) w_state_nxt = S_WAIT_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rho_shadow  <= RHO_RST;
            r_rho_out     <= RHO_RST;
            r_sample      <= '0;
            r_step_count  <= '0;
            r_overrun     <= '0;
            r_timeout_err <= 1'b0;
            r_pending     <= 1'b0;
            r_mask        <= '0;
            r_timer       <= '0;
        end else begin
            if (rho_wr) r_rho_shadow <= rho_in;

            // rho only moves at a step boundary; a same-cycle write lands in the next step.
            if (r_state == S_START) begin
                r_rho_out <= r_rho_shadow;
                r_mask    <= '0;
                r_timer   <= '0;
            end

            if (r_state == S_COLLECT) begin
                r_mask  <= w_mask_nxt;
                r_timer <= r_timer + TW'(1);
                if (w_mask_full) begin
                    r_sample     <= center_amp;
                    r_step_count <= r_step_count + 32'd1;
                end else if (w_timeout) begin
                    r_timeout_err <= 1'b1;
                end
            end

            if (w_take_req) begin
                r_pending <= 1'b0;
            end else if (audio_req && (r_state != S_WAIT_REQ)) begin
                if (!r_pending)              r_pending <= 1'b1;
                else if (r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
            end
        end
    end

    assign rho_out     = r_rho_out;
    assign sample_out  = r_sample;
    assign step_count  = r_step_count;
    assign overrun_cnt = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_column_step_scheduler.sv
// Directed bench for column_step_scheduler: step sequencing, rho hand-off,
// request overrun, timeout and reset abort.
module tb_column_step_scheduler;

    logic               clk = 1'b0;
    logic               rst, run, audio_req, rho_wr, init_done, sample_ready;
    logic [17:0]        rho_in;
    logic [7:0]         col_done_vec;
    logic signed [17:0] center_amp;
    logic [17:0]        rho_out;
    logic               init_req, col_start, sample_valid, timeout_err, busy;
    logic signed [17:0] sample_out;
    logic [31:0]        step_count;
    logic [7:0]         overrun_cnt;

    int total = 0;
    int bad = 0;
    int n_start = 0;

    column_step_scheduler dut (
        .clk(clk), .rst(rst), .run(run), .audio_req(audio_req),
        .rho_in(rho_in), .rho_wr(rho_wr), .rho_out(rho_out),
        .init_req(init_req), .init_done(init_done),
        .col_start(col_start), .col_done_vec(col_done_vec),
        .center_amp(center_amp), .sample_out(sample_out),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .step_count(step_count), .overrun_cnt(overrun_cnt),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (col_start === 1'b1) n_start++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete step from WAIT_REQ back to WAIT_REQ, no checks.
    task automatic plain_step;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        tick;
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        sample_ready = 1'b1; tick; sample_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b0; audio_req = 1'b0; rho_wr = 1'b0; rho_in = '0;
        init_done = 1'b0; sample_ready = 1'b0; col_done_vec = '0; center_amp = '0;
        tick; tick;
        total++; if (rho_out !== 18'h01000) begin bad++; $display("FAIL rst_rho got=%h exp=01000", rho_out); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sample_valid); end
        total++; if (step_count !== 32'd0) begin bad++; $display("FAIL rst_steps got=%0d exp=0", step_count); end
        total++; if (busy !== 1'b0 || init_req !== 1'b0 || col_start !== 1'b0) begin bad++; $display("FAIL rst_ctrl got busy=%b init=%b start=%b exp=000", busy, init_req, col_start); end
        rst = 1'b0;
        tick;
        total++; if (busy !== 1'b0 || init_req !== 1'b0) begin bad++; $display("FAIL rst_idle got busy=%b init=%b exp=00", busy, init_req); end
    endtask

    task automatic test_basic;
        run = 1'b1;
        tick;
        total++; if (init_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL basic_init got init=%b busy=%b exp=11", init_req, busy); end
        repeat (4) tick;
        total++; if (init_req !== 1'b1) begin bad++; $display("FAIL basic_init_hold got=%b exp=1", init_req); end
        init_done = 1'b1; tick; init_done = 1'b0;
        total++; if (init_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_wait got init=%b busy=%b exp=00", init_req, busy); end
        center_amp = 18'h00400; sample_ready = 1'b1; n_start = 0;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        total++; if (col_start !== 1'b1) begin bad++; $display("FAIL basic_start got=%b exp=1", col_start); end
        tick;
        total++; if (col_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_collect got start=%b busy=%b exp=01", col_start, busy); end
        tick; tick;
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL basic_emit got=%b exp=1", sample_valid); end
        total++; if (sample_out !== 18'h00400) begin bad++; $display("FAIL basic_sample got=%h exp=00400", sample_out); end
        total++; if (step_count !== 32'd1) begin bad++; $display("FAIL basic_steps got=%0d exp=1", step_count); end
        tick;
        total++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_back got valid=%b busy=%b exp=00", sample_valid, busy); end
        sample_ready = 1'b0;
        tick; tick;
        total++; if (init_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_stay_wait got init=%b busy=%b exp=00", init_req, busy); end
        total++; if (n_start !== 1) begin bad++; $display("FAIL basic_nstart got=%0d exp=1", n_start); end
    endtask

    task automatic test_stagger;
        center_amp = 18'h3FF00;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        tick;
        for (int i = 0; i < 8; i++) begin
            col_done_vec = 8'(1 << i);
            tick;
            if (i < 7) begin
                total++; if (sample_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stagger_early bit=%0d got valid=%b busy=%b exp=01", i, sample_valid, busy); end
            end
        end
        col_done_vec = 8'h00;
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL stagger_emit got=%b exp=1", sample_valid); end
        total++; if (sample_out !== 18'h3FF00) begin bad++; $display("FAIL stagger_sample got=%h exp=3ff00", sample_out); end
        total++; if (step_count !== 32'd2) begin bad++; $display("FAIL stagger_steps got=%0d exp=2", step_count); end
        sample_ready = 1'b1; tick; sample_ready = 1'b0;
    endtask

    task automatic test_rho;
        total++; if (rho_out !== 18'h01000) begin bad++; $display("FAIL rho_init got=%h exp=01000", rho_out); end
        audio_req = 1'b1; tick; audio_req = 1'b0;
        tick;
        rho_wr = 1'b1; rho_in = 18'h02000; tick; rho_wr = 1'b0;
        total++; if (rho_out !== 18'h01000) begin bad++; $display("FAIL rho_collect got=%h exp=01000", rho_out); end
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        total++; if (rho_out !== 18'h01000) begin bad++; $display("FAIL rho_emit got=%h exp=01000", rho_out); end
        sample_ready = 1'b1; tick; sample_ready = 1'b0;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        total++; if (rho_out !== 18'h01000) begin bad++; $display("FAIL rho_in_start got=%h exp=01000", rho_out); end
        rho_wr = 1'b1; rho_in = 18'h03000; tick; rho_wr = 1'b0;
        total++; if (rho_out !== 18'h02000) begin bad++; $display("FAIL rho_applied got=%h exp=02000", rho_out); end
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        sample_ready = 1'b1; tick; sample_ready = 1'b0;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        tick;
        total++; if (rho_out !== 18'h03000) begin bad++; $display("FAIL rho_same_cycle got=%h exp=03000", rho_out); end
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        sample_ready = 1'b1; tick; sample_ready = 1'b0;
        total++; if (step_count !== 32'd5) begin bad++; $display("FAIL rho_steps got=%0d exp=5", step_count); end
    endtask

    task automatic test_overrun;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        tick;
        repeat (3) begin
            audio_req = 1'b1; tick; audio_req = 1'b0; tick;
        end
        total++; if (overrun_cnt !== 8'd2) begin bad++; $display("FAIL ovr_count got=%0d exp=2", overrun_cnt); end
        center_amp = 18'h00123;
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        center_amp = 18'h2AAAA;
        for (int i = 0; i < 10; i++) begin
            total++; if (sample_valid !== 1'b1 || sample_out !== 18'h00123) begin bad++; $display("FAIL ovr_hold cyc=%0d got valid=%b out=%h exp=1/00123", i, sample_valid, sample_out); end
            tick;
        end
        sample_ready = 1'b1; tick;
        total++; if (col_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ovr_wait got start=%b busy=%b exp=00", col_start, busy); end
        tick;
        total++; if (col_start !== 1'b1) begin bad++; $display("FAIL ovr_pending_start got=%b exp=1", col_start); end
        tick;
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        tick; sample_ready = 1'b0;
        tick;
        total++; if (col_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ovr_pending_clear got start=%b busy=%b exp=00", col_start, busy); end
        total++; if (overrun_cnt !== 8'd2 || step_count !== 32'd7) begin bad++; $display("FAIL ovr_end got ovr=%0d steps=%0d exp=2/7", overrun_cnt, step_count); end
    endtask

    task automatic test_run_drop;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        run = 1'b0; tick;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_collect got busy=%b exp=1", busy); end
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL drop_emit got=%b exp=1", sample_valid); end
        sample_ready = 1'b1; tick; sample_ready = 1'b0;
        total++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drop_wait got valid=%b busy=%b exp=00", sample_valid, busy); end
        tick;
        run = 1'b1; tick;
        total++; if (init_req !== 1'b1) begin bad++; $display("FAIL drop_reinit got=%b exp=1", init_req); end
        init_done = 1'b1; tick; init_done = 1'b0;
        total++; if (step_count !== 32'd8 || init_req !== 1'b0) begin bad++; $display("FAIL drop_end got steps=%0d init=%b exp=8/0", step_count, init_req); end
    endtask

    task automatic test_timeout;
        int  n;
        logic sv_seen;
        n = 0; sv_seen = 1'b0;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        col_done_vec = 8'hF7; tick;
        while (busy === 1'b1 && n < 1100) begin
            if (sample_valid !== 1'b0) sv_seen = 1'b1;
            tick;
            n++;
        end
        col_done_vec = 8'h00;
        total++; if (n !== 1023) begin bad++; $display("FAIL to_cycles got=%0d exp=1023", n); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", timeout_err); end
        total++; if (sv_seen !== 1'b0) begin bad++; $display("FAIL to_no_sample got=%b exp=0", sv_seen); end
        total++; if (step_count !== 32'd8) begin bad++; $display("FAIL to_steps got=%0d exp=8", step_count); end
        tick;
        total++; if (init_req !== 1'b1 || timeout_err !== 1'b1) begin bad++; $display("FAIL to_reinit got init=%b err=%b exp=11", init_req, timeout_err); end
        init_done = 1'b1; tick; init_done = 1'b0;
    endtask

    task automatic test_reset_emit;
        audio_req = 1'b1; tick; audio_req = 1'b0;
        tick;
        center_amp = 18'h1ABCD;
        col_done_vec = 8'hFF; tick; col_done_vec = 8'h00;
        total++; if (sample_valid !== 1'b1 || sample_out !== 18'h1ABCD) begin bad++; $display("FAIL rste_emit got valid=%b out=%h exp=1/1abcd", sample_valid, sample_out); end
        audio_req = 1'b1; tick; audio_req = 1'b0;
        rst = 1'b1; run = 1'b0; tick;
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rste_valid got=%b exp=0", sample_valid); end
        total++; if (rho_out !== 18'h01000 || sample_out !== 18'h00000) begin bad++; $display("FAIL rste_data got rho=%h out=%h exp=01000/00000", rho_out, sample_out); end
        total++; if (step_count !== 32'd0 || overrun_cnt !== 8'd0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rste_stats got steps=%0d ovr=%0d err=%b exp=0/0/0", step_count, overrun_cnt, timeout_err); end
        total++; if (busy !== 1'b0 || col_start !== 1'b0 || init_req !== 1'b0) begin bad++; $display("FAIL rste_ctrl got busy=%b start=%b init=%b exp=000", busy, col_start, init_req); end
        rst = 1'b0; run = 1'b1; tick;
        init_done = 1'b1; tick; init_done = 1'b0;
        tick; tick;
        total++; if (col_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rste_pending got start=%b busy=%b exp=00", col_start, busy); end
        plain_step;
        total++; if (rho_out !== 18'h01000 || step_count !== 32'd1) begin bad++; $display("FAIL rste_shadow got rho=%h steps=%0d exp=01000/1", rho_out, step_count); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        test_reset;
        test_basic;
        test_stagger;
        test_rho;
        test_overrun;
        test_run_drop;
        test_timeout;
        test_reset_emit;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/column_step_scheduler.md
COLUMN_STEP_SCHEDULER -- requirements
Module: column_step_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_COL, default 8, giving the number of column compute units sequenced.
REQ-002 The block SHALL have parameter TIMEOUT, default 1023, giving the maximum cycles allowed in COLLECT.
REQ-003 The block SHALL have parameter RHO_RST, default 18'h01000, giving the rho value after reset (1.17 format, 1/32).
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all logic on posedge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port run, input, 1 bit: level enable for stepping.
REQ-007 The block SHALL have port audio_req, input, 1 bit: single-cycle pulse requesting one new sample.
REQ-008 The block SHALL have ports rho_in, input, 18 bits, and rho_wr, input, 1 bit: rho value and its write strobe.
REQ-009 The block SHALL have port rho_out, output, 18 bits: rho driven to all columns.
REQ-010 The block SHALL have ports init_req, output, 1 bit, and init_done, input, 1 bit: initial-condition load handshake.
REQ-011 The block SHALL have ports col_start, output, 1 bit, and col_done_vec, input, NUM_COL bits: step start pulse and per-column done pulses.
REQ-012 The block SHALL have port center_amp, input, 18 bits signed: centre-node u_np1 from the middle column.
REQ-013 The block SHALL have ports sample_out, output, 18 bits signed; sample_valid, output, 1 bit; and sample_ready, input, 1 bit: valid/ready sample stream.
REQ-014 The block SHALL have ports step_count, output, 32 bits; overrun_cnt, output, 8 bits; timeout_err, output, 1 bit; and busy, output, 1 bit.

Function
REQ-015 The FSM SHALL have the states IDLE, INIT, WAIT_REQ, START, COLLECT and EMIT.
REQ-016 In IDLE, when run=1, the FSM SHALL go to INIT and assert init_req on the following cycle.
REQ-017 In INIT, init_req SHALL stay high until init_done=1 is sampled, then deassert; the FSM SHALL go to WAIT_REQ.
REQ-018 In WAIT_REQ: if run=0, the FSM SHALL go to IDLE; else if audio_req=1 or pending=1, it SHALL clear pending and go to START.
REQ-019 START SHALL last exactly 1 cycle, assert col_start=1, copy the rho shadow register to rho_out, and clear the done mask; the next state SHALL be COLLECT.
REQ-020 In COLLECT, mask SHALL become mask OR col_done_vec each cycle; col_done_vec SHALL be ignored in all other states.
REQ-021 When the mask is all ones, center_amp SHALL be captured into sample_out, step_count SHALL increment (wrapping at 2^32), and the FSM SHALL go to EMIT.
REQ-022 If COLLECT lasts TIMEOUT cycles without a full mask, timeout_err SHALL be set (sticky until rst) and the FSM SHALL go to IDLE with no sample emitted.
REQ-023 In EMIT, sample_valid SHALL be 1 and sample_out SHALL be held stable; on sample_valid AND sample_ready the FSM SHALL go to WAIT_REQ, with sample_valid falling the next cycle.
REQ-024 An audio_req outside WAIT_REQ SHALL set pending; if pending is already 1, overrun_cnt SHALL increment instead, saturating at 255.
REQ-025 rho_wr SHALL load rho_in into the shadow register at any time; rho_out SHALL change only in START, so rho is never changed mid-step.
REQ-026 If rho_wr occurs in the same cycle as START, the old shadow SHALL be applied and the new value used from the next step.
REQ-027 If run drops during START, COLLECT or EMIT, the current step SHALL complete, including the EMIT handshake, before the FSM returns to IDLE via WAIT_REQ.
REQ-028 A new run=1 from IDLE SHALL always reinitialise the columns through INIT.
REQ-029 busy SHALL equal 1 in every state except IDLE and WAIT_REQ.

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE, and on the cycle after, outputs SHALL be: rho_out = shadow = RHO_RST; sample_out=0; sample_valid=0; col_start=0; init_req=0; step_count=0; overrun_cnt=0; timeout_err=0; busy=0; pending=0; mask=0.
REQ-031 rst asserted in any state, including mid-COLLECT or mid-EMIT, SHALL abort the operation immediately with no further col_start or sample_valid.

Verification
REQ-032 Bench scenario: run=1, init_done after 5 cycles, audio_req, all done bits 3 cycles after col_start, center_amp=18'h00400, sample_ready=1 -> exactly one col_start pulse, sample_out=18'h00400, step_count=1, back in WAIT_REQ.
REQ-033 Bench scenario: done bits arrive staggered, columns 0..7 one per cycle -> EMIT is entered only in the cycle after bit 7 is seen, and the mask is not cleared early.
REQ-034 Bench scenario: rho_wr=18'h02000 during COLLECT -> rho_out stays 18'h01000 until the next START, then becomes 18'h02000.
REQ-035 Bench scenario: three audio_req pulses during one COLLECT with sample_ready held 0 for 10 cycles -> pending=1, overrun_cnt=2, and the next step starts right after the handshake.
REQ-036 Bench scenario: column 3 never reports done -> timeout_err=1 after 1023 cycles in COLLECT, FSM in IDLE, sample_valid never asserted.
REQ-037 Bench scenario: rst pulsed during EMIT with sample_valid=1 -> the next cycle gives sample_valid=0 and all REQ-030 values.
